fp_mul_pipe: RTL and testbench

//  Parametrised 3-stage pipelined floating-point multiplier for the fragment FP datapath.

---
 rtl/fp_mul_pipe_if.sv | 32 +++
 rtl/fp_mul_pipe.sv | 151 +++++++++++++++
 tb/tb_fp_mul_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for fp_mul_pipe
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 15,
    parameter int TAG_W = 4
) ();
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             rnd_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] out_tag;
    logic             flag_zero;
    logic             flag_ovf;
    logic             flag_unf;

    modport master (
        output in_valid, a, b, rnd_mode, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, flag_zero, flag_ovf, flag_unf
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, flag_zero, flag_ovf, flag_unf
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined FP multiplier with rounding, saturation and tag pass-through
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 15,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mul_pipe_if.slave  io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] BIAS_E = EW'(2 ** (EXP_W - 1) - 1);

    logic adv;
    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;

    logic [EXP_W-1:0] ea, eb;
    logic             za, zb;
    logic [MAN_W:0]   ma, mb;
    logic [PW-1:0]    p_n;
    logic [EW-1:0]    es_n;

    assign ea   = io.a[W-2:MAN_W];
    assign eb   = io.b[W-2:MAN_W];
    assign za   = (ea == '0);
    assign zb   = (eb == '0);
    assign ma   = {!za, io.a[MAN_W-1:0]};
    assign mb   = {!zb, io.b[MAN_W-1:0]};
    assign p_n  = PW'(ma) * PW'(mb);
    assign es_n = {2'b00, ea} + {2'b00, eb} - BIAS_E;

    logic             v1, sign1, z1, rnd1;
    logic [PW-1:0]    p1;
    logic [EW-1:0]    es1;
    logic [TAG_W-1:0] tag1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            p1    <= '0;
            es1   <= '0;
            sign1 <= 1'b0;
            z1    <= 1'b0;
            rnd1  <= 1'b0;
            tag1  <= '0;
        end else if (adv) begin
            v1    <= io.in_valid;
            p1    <= p_n;
            es1   <= es_n;
            sign1 <= io.a[W-1] ^ io.b[W-1];
            z1    <= za || zb;
            rnd1  <= io.rnd_mode;
            tag1  <= io.in_tag;
        end
    end

    logic             top;
    logic [MAN_W-1:0] mant_n;
    logic             guard_n, sticky_n;
    logic [EW-1:0]    e2_n;

    assign top      = p1[PW-1];
    assign mant_n   = top ? p1[PW-2 -: MAN_W] : p1[PW-3 -: MAN_W];
    assign guard_n  = top ? p1[PW-2-MAN_W] : p1[PW-3-MAN_W];
    assign sticky_n = top ? |p1[PW-3-MAN_W:0] : |p1[PW-4-MAN_W:0];
    assign e2_n     = es1 + EW'(top);

    logic             v2, sign2, z2, rnd2, guard2, sticky2;
    logic [MAN_W-1:0] mant2;
    logic [EW-1:0]    e2;
    logic [TAG_W-1:0] tag2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            mant2   <= '0;
            guard2  <= 1'b0;
            sticky2 <= 1'b0;
            e2      <= '0;
            sign2   <= 1'b0;
            z2      <= 1'b0;
            rnd2    <= 1'b0;
            tag2    <= '0;
        end else if (adv) begin
            v2      <= v1;
            mant2   <= mant_n;
            guard2  <= guard_n;
            sticky2 <= sticky_n;
            e2      <= e2_n;
            sign2   <= sign1;
            z2      <= z1;
            rnd2    <= rnd1;
            tag2    <= tag1;
        end
    end

    logic           inc;
    logic [MAN_W:0] sum;
    logic [EW-1:0]  e3;
    logic           unf_c, ovf_c;
    logic [W-1:0]   res_c;
    logic           fz_c, fo_c, fu_c;

    // A fraction carry leaves the low bits all zero, so sum's low bits are already the packed fraction.
    assign inc   = rnd2 && guard2 && (sticky2 || mant2[0]);
    assign sum   = {1'b0, mant2} + (MAN_W + 1)'(inc);
    assign e3    = e2 + EW'(sum[MAN_W]);
    // e3 is two's complement: top bit is the sign, bit EXP_W set on a positive value means > 2^EXP_W-1.
    assign unf_c = e3[EW-1] || (e3 == '0);
    assign ovf_c = !e3[EW-1] && e3[EXP_W];

    always_comb begin
        res_c = {sign2, e3[EXP_W-1:0], sum[MAN_W-1:0]};
        fz_c  = 1'b0;
        fo_c  = 1'b0;
        fu_c  = 1'b0;
        if (z2) begin
            res_c = {sign2, {(W-1){1'b0}}};
            fz_c  = 1'b1;
        end else if (unf_c) begin
            res_c = {sign2, {(W-1){1'b0}}};
            fz_c  = 1'b1;
            fu_c  = 1'b1;
        end else if (ovf_c) begin
            res_c = {W{1'b1}};
            res_c[W-1] = sign2;
            fo_c  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.result    <= '0;
            io.out_tag   <= '0;
            io.flag_zero <= 1'b0;
            io.flag_ovf  <= 1'b0;
            io.flag_unf  <= 1'b0;
        end else if (adv) begin
            io.out_valid <= v2;
            io.result    <= res_c;
            io.out_tag   <= tag2;
            io.flag_zero <= fz_c;
            io.flag_ovf  <= fo_c;
            io.flag_unf  <= fu_c;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - self-checking bench for fp_mul_pipe
module tb_fp_mul_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 15;
    localparam int TAG_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = 2 ** (EXP_W - 1) - 1;

    typedef struct packed {
        logic [W-1:0]     res;
        logic [TAG_W-1:0] tag;
        logic             z;
        logic             o;
        logic             u;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) io ();
    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .io(io));

    exp_t             sbq[$];
    exp_t             mon_e;
    int               vectors  = 0;
    int               errors   = 0;
    int               received = 0;
    logic [TAG_W-1:0] tag_ctr;
    logic             held = 1'b0;
    logic [W-1:0]     held_res;
    logic [TAG_W-1:0] held_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Exact product of the significands, normalised and rounded with integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input bit r,
                                   input logic [TAG_W-1:0] t);
        exp_t   o;
        longint mx, my, prod, m, rem, half;
        int     e, sh;
        logic   s;
        o     = '0;
        o.tag = t;
        s     = x[W-1] ^ y[W-1];
        if (x[W-2:MAN_W] == 0 || y[W-2:MAN_W] == 0) begin
            o.res = {s, {(W-1){1'b0}}};
            o.z   = 1'b1;
            return o;
        end
        mx   = longint'({1'b1, x[MAN_W-1:0]});
        my   = longint'({1'b1, y[MAN_W-1:0]});
        prod = mx * my;
        e    = int'(x[W-2:MAN_W]) + int'(y[W-2:MAN_W]) - BIAS;
        sh   = MAN_W;
        if (prod >= (64'sd1 <<< (2 * MAN_W + 1))) begin
            sh = MAN_W + 1;
            e++;
        end
        m    = prod >>> sh;
        rem  = prod - (m <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (r && (rem > half || (rem == half && m[0]))) m++;
        if (m == (64'sd1 <<< (MAN_W + 1))) begin
            m = m >>> 1;
            e++;
        end
        if (e <= 0) begin
            o.res = {s, {(W-1){1'b0}}};
            o.z   = 1'b1;
            o.u   = 1'b1;
        end else if (e > (1 << EXP_W) - 1) begin
            o.res = {s, {(W-1){1'b1}}};
            o.o   = 1'b1;
        end else begin
            o.res = {s, EXP_W'(e), m[MAN_W-1:0]};
        end
        return o;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [EXP_W-1:0] e;
        case ($urandom % 5)
            0:       e = EXP_W'($urandom_range(0, 8));
            1:       e = EXP_W'($urandom_range(190, 255));
            2:       e = EXP_W'($urandom_range(50, 75));
            default: e = EXP_W'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, MAN_W'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(io.in_ready), 64'(!io.out_valid || io.out_ready));
            if (held) begin
                chk("hold_valid", 64'(io.out_valid), 64'd1);
                chk("hold_result", 64'(io.result), 64'(held_res));
                chk("hold_tag", 64'(io.out_tag), 64'(held_tag));
            end
            if (io.out_valid && io.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    received++;
                    chk("result", 64'(io.result), 64'(mon_e.res));
                    chk("out_tag", 64'(io.out_tag), 64'(mon_e.tag));
                    chk("flags", 64'({io.flag_zero, io.flag_ovf, io.flag_unf}),
                        64'({mon_e.z, mon_e.o, mon_e.u}));
                end
            end
            held     = io.out_valid && !io.out_ready;
            held_res = io.result;
            held_tag = io.out_tag;
        end
    end

    task automatic cyc(input bit v, input logic [W-1:0] x, input logic [W-1:0] y, input bit r,
                       input bit ordy, output bit took);
        io.in_valid  = v;
        io.a         = x;
        io.b         = y;
        io.rnd_mode  = r;
        io.in_tag    = tag_ctr;
        io.out_ready = ordy;
        @(negedge clk);
        took = v && io.in_ready && rst_n;
        if (took) begin
            sbq.push_back(model(x, y, r, tag_ctr));
            tag_ctr++;
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit t;
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            cyc(0, '0, '0, 0, 1, t);
            n++;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input bit r, input logic [W-1:0] eres, input logic [2:0] eflags);
        bit took;
        int lat = 0;
        cyc(1, x, y, r, 1, took);
        chk({name, "_accept"}, 64'(took), 64'd1);
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (io.out_valid) break;
            @(posedge clk);
        end
        chk({name, "_latency"}, 64'(lat), 64'd3);
        chk({name, "_result"}, 64'(io.result), 64'(eres));
        chk({name, "_flags"}, 64'({io.flag_zero, io.flag_ovf, io.flag_unf}), 64'(eflags));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit took;
        int sent;
        int rx0;
        rst_n        = 1'b0;
        tag_ctr      = '0;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.rnd_mode  = 1'b0;
        io.in_tag    = '0;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_result", 64'(io.result), 64'd0);
        chk("rst_out_tag", 64'(io.out_tag), 64'd0);
        chk("rst_flags", 64'({io.flag_zero, io.flag_ovf, io.flag_unf}), 64'd0);
        chk("rst_in_ready", 64'(io.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("t1", 24'h3FC000, 24'h3FC000, 0, 24'h401000, 3'b000);
        directed("t2_trunc", 24'h3F8001, 24'h3FC000, 0, 24'h3FC001, 3'b000);
        directed("t2_rne", 24'h3F8001, 24'h3FC000, 1, 24'h3FC002, 3'b000);
        directed("t3_zero", 24'h000000, 24'hBF8000, 0, 24'h800000, 3'b100);
        directed("t3_unf", 24'h008000, 24'h008000, 0, 24'h000000, 3'b101);
        directed("t4_ovf", 24'h7F8000, 24'hFF8000, 0, 24'hFFFFFF, 3'b010);
        directed("emax_ok", 24'h7F8000, 24'h3F8000, 0, 24'h7F8000, 3'b000);
        directed("e_zero_unf", 24'h008000, 24'h3F0000, 0, 24'h000000, 3'b101);

        for (int i = 0; i < 400; i++)
            cyc(($urandom % 4) != 0, rand_op(), rand_op(), 1'($urandom), ($urandom % 4) != 0, took);
        drain();

        tag_ctr = '0;
        sent    = 0;
        rx0     = received;
        for (int c = 0; c < 12; c++) begin
            cyc(sent < 8, rand_op(), rand_op(), 1'($urandom), !(c >= 2 && c < 7), took);
            if (took) sent++;
        end
        drain();
        chk("t5_sent", 64'(sent), 64'd8);
        chk("t5_received", 64'(received - rx0), 64'd8);

        tag_ctr = '0;
        for (int i = 0; i < 3; i++) cyc(1, rand_op(), rand_op(), 0, 1, took);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_in_reset", 64'(io.out_valid), 64'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_idle_valid", 64'(io.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        directed("t6_after", 24'h3FC000, 24'h3FC000, 0, 24'h401000, 3'b000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
